// File: rtl/output_layer_mac.sv
// Output dense layer: 30 activations x 10 neurons, one MAC per clock, then argmax.
// Build option OL_SAT_EN clamps each score to the signed 8-bit range instead of wrapping.
module output_layer_mac #(
  parameter int N_IN      = 30,
  parameter int N_OUT     = 10,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 6,
  parameter int ACC_W     = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [DATA_W*N_IN-1:0]         act_in,
  input  logic [DATA_W*N_OUT*N_IN-1:0]   weights_OL,
  input  logic [DATA_W*N_OUT-1:0]        biases_OL,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_W*N_OUT-1:0]        scores,
  output logic [3:0]                     digit
);

  localparam int IW   = $clog2(N_OUT);
  localparam int JW   = $clog2(N_IN);
  localparam int WB_W = $clog2(DATA_W*N_OUT*N_IN);
  localparam int AB_W = $clog2(DATA_W*N_IN);
  localparam int BB_W = $clog2(DATA_W*N_OUT);
  localparam int PW   = 2*DATA_W;

  typedef enum logic [1:0] {IDLE, MAC, STORE} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              i_q, i_d;
  logic [JW-1:0]              j_q, j_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W*N_IN-1:0]     act_q, act_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [DATA_W-1:0]          max_q, max_d;
  logic [3:0]                 digit_q, digit_d;
  logic [DATA_W-1:0]          score_q [N_OUT];
  logic [DATA_W-1:0]          score_d [N_OUT];

  logic [DATA_W-1:0]          a_sel, w_sel, b_sel;
  logic signed [PW-1:0]       prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_acc;
  logic [IW-1:0]              b_idx;
  logic [DATA_W-1:0]          score_new;
  logic                       last_neuron;

`ifdef OL_SAT_EN
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(2**(DATA_W-1)-1);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(2**(DATA_W-1)));
  logic signed [ACC_W-1:0]    r;
`endif

  // Datapath: operand selection from the flattened buses, product, bias preload, narrowing
  always_comb begin
    last_neuron = (i_q == IW'(N_OUT-1));
    a_sel = act_q[AB_W'(int'(j_q)*DATA_W) +: DATA_W];
    w_sel = weights_OL[WB_W'((int'(i_q)*N_IN + int'(j_q))*DATA_W) +: DATA_W];
    prod  = $signed({{DATA_W{a_sel[DATA_W-1]}}, a_sel}) *
            $signed({{DATA_W{w_sel[DATA_W-1]}}, w_sel});
    prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    // In IDLE the preload is bias 0; in STORE it is the next neuron's bias
    b_idx = (state_q == IDLE || last_neuron) ? '0 : i_q + 1'b1;
    b_sel = biases_OL[BB_W'(int'(b_idx)*DATA_W) +: DATA_W];
    bias_acc = {{(ACC_W-DATA_W){b_sel[DATA_W-1]}}, b_sel} <<< FRAC_BITS;
`ifdef OL_SAT_EN
    r = acc_q >>> FRAC_BITS;
    if (r > S_MAX)      score_new = S_MAX[DATA_W-1:0];
    else if (r < S_MIN) score_new = S_MIN[DATA_W-1:0];
    else                score_new = r[DATA_W-1:0];
`else
    score_new = acc_q[FRAC_BITS +: DATA_W];
`endif
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    act_d   = act_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    max_d   = max_q;
    digit_d = digit_q;
    score_d = score_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          act_d   = act_in;
          i_d     = '0;
          j_d     = '0;
          acc_d   = bias_acc;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        if (j_q == JW'(N_IN-1)) state_d = STORE;
        else                    j_d = j_q + 1'b1;
      end
      STORE: begin
        score_d[i_q] = score_new;
        // Strict compare keeps the lowest index on ties
        if (i_q == '0 || $signed(score_new) > $signed(max_q)) begin
          max_d   = score_new;
          digit_d = 4'(i_q);
        end
        if (!last_neuron) begin
          i_d     = i_q + 1'b1;
          j_d     = '0;
          acc_d   = bias_acc;
          state_d = MAC;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      act_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      max_q   <= '0;
      digit_q <= '0;
      for (int k = 0; k < N_OUT; k++) score_q[k] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      max_q   <= max_d;
      digit_q <= digit_d;
      for (int k = 0; k < N_OUT; k++) score_q[k] <= score_d[k];
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    assign scores[k*DATA_W +: DATA_W] = score_q[k];
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign digit = digit_q;

endmodule

// File: tb/tb_output_layer_mac.sv
// Directed + random bench for output_layer_mac against an arithmetic reference model.
module tb_output_layer_mac;
  localparam int N_IN = 30, N_OUT = 10, DW = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [DW*N_IN-1:0]       act_bus = '0;
  logic [DW*N_OUT*N_IN-1:0] w_bus = '0;
  logic [DW*N_OUT-1:0]      b_bus = '0;
  logic                     busy, done;
  logic [DW*N_OUT-1:0]      scores;
  logic [3:0]               digit;

  int act [N_IN];
  int w   [N_OUT][N_IN];
  int b   [N_OUT];
  int exp_sc [N_OUT];
  int exp_dig;
  int vecs = 0, errs = 0;

  output_layer_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .act_in(act_bus),
    .weights_OL(w_bus), .biases_OL(b_bus),
    .busy(busy), .done(done), .scores(scores), .digit(digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic pack();
    int t;
    for (int j = 0; j < N_IN; j++) begin t = act[j]; act_bus[j*DW +: DW] = t[DW-1:0]; end
    for (int i = 0; i < N_OUT; i++) begin
      t = b[i]; b_bus[i*DW +: DW] = t[DW-1:0];
      for (int j = 0; j < N_IN; j++) begin
        t = w[i][j]; w_bus[(i*N_IN+j)*DW +: DW] = t[DW-1:0];
      end
    end
  endtask

  task automatic fill(input int a, input int wv, input int bv);
    for (int j = 0; j < N_IN; j++) act[j] = a;
    for (int i = 0; i < N_OUT; i++) begin
      b[i] = bv;
      for (int j = 0; j < N_IN; j++) w[i][j] = wv;
    end
  endtask

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  // Dot product plus scaled bias, floor-divide by 64, narrow, then argmax (ties -> lowest)
  task automatic model();
    int acc, r, s, best;
    best = 0;
    for (int i = 0; i < N_OUT; i++) begin
      acc = b[i] * 64;
      for (int j = 0; j < N_IN; j++) acc += act[j] * w[i][j];
      r = (acc >= 0) ? acc / 64 : -((-acc + 63) / 64);
`ifdef OL_SAT_EN
      s = (r > 127) ? 127 : (r < -128) ? -128 : r;
`else
      s = ((r % 256) + 256) % 256;
      if (s > 127) s -= 256;
`endif
      exp_sc[i] = s;
      if (i == 0 || s > best) begin best = s; exp_dig = i; end
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < N_OUT; i++)
      chk($sformatf("%s score%0d", tag, i), int'($signed(scores[i*DW +: DW])), exp_sc[i]);
    chk({tag, " digit"}, int'(digit), exp_dig);
  endtask

  // Called #1 after the accept edge; returns #1 after the done edge (or bound expiry)
  task automatic wait_done(input string tag, input bit pulse, input bit hold);
    int n;
    bit got;
    n = 0; got = 0;
    chk({tag, " busy after accept"}, int'(busy), 1);
    while (n < 400 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
      else if (!hold) start = (pulse && (n == 50 || n == 200));
    end
    chk({tag, " latency"}, got ? n : -1, 310);
    chk({tag, " busy at done"}, int'(busy), 0);
    check_results(tag);
  endtask

  task automatic run(input string tag, input bit pulse);
    model();
    pack();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(tag, pulse, 1'b0);
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, int'(done), 0);
  endtask

  initial begin
    int dn;
    fill(0, 0, 0);
    pack();
    #23;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset digit", int'(digit), 0);
    chk("reset scores", (scores == '0) ? 0 : 1, 0);
    @(negedge clk) rst_n = 1'b1;

    fill(0, 0, 0); b[3] = 16;
    run("bias3", 1'b0);

    fill(0, 0, 0); act[0] = 64;
    for (int i = 0; i < N_OUT; i++) w[i][0] = 10 * i;
    run("ramp", 1'b0);

    fill(127, 127, 127);
    run("allmax", 1'b0);

    fill(-128, 127, -128);
    run("allmin", 1'b0);

    fill(0, 0, 0); act[0] = -64;
    for (int i = 0; i < N_OUT; i++) w[i][0] = 1;
    run("floor", 1'b0);

    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < N_IN; j++) act[j] = rnd8();
      for (int i = 0; i < N_OUT; i++) begin
        b[i] = rnd8();
        for (int j = 0; j < N_IN; j++) w[i][j] = (t == 0) ? rnd8() : rnd8() / 4;
      end
      run($sformatf("rand%0d", t), 1'b0);
    end

    // Spurious starts mid-run must be ignored
    for (int j = 0; j < N_IN; j++) act[j] = rnd8();
    run("ignore_start", 1'b1);

    // Reset mid-run aborts with no done
    model(); pack();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort digit", int'(digit), 0);
    chk("abort scores", (scores == '0) ? 0 : 1, 0);
    @(negedge clk) rst_n = 1'b1;
    dn = 0;
    repeat (330) begin @(posedge clk); #1 if (done) dn++; end
    chk("abort no done", dn, 0);
    run("after_abort", 1'b0);

    // Back-to-back: start held through done; act_in changes after first accept
    for (int j = 0; j < N_IN; j++) act[j] = rnd8();
    for (int i = 0; i < N_OUT; i++)
      for (int j = 0; j < N_IN; j++) w[i][j] = rnd8() / 2;
    model(); pack();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < N_IN; j++) act[j] = rnd8();
    pack();
    wait_done("b2b first", 1'b0, 1'b1);
    model();
    @(posedge clk); #1 start = 1'b0;
    wait_done("b2b second", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/output_layer_mac.md
Name: output_layer_mac

Overview:
Sequential inference engine for the final dense layer (30 hidden activations -> 10 digit scores). It consumes the flattened weight/bias buses driven by the output-layer parameter block and the hidden-layer activation vector. It runs one multiply-accumulate per clock and reports 10 scores plus the winning digit. It sits between the hidden-layer stage and the display/result logic.

Parameters:
N_IN, 30, activations per neuron
N_OUT, 10, output neurons
DATA_W, 8, signed width of activations, weights, biases, scores
FRAC_BITS, 6, fractional bits of the fixed-point format (Q1.6)
ACC_W, 24, signed accumulator width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request one inference; sampled only in IDLE
act_in  in  DATA_W*N_IN  activations; act j = act_in[j*8 +: 8]
weights_OL  in  DATA_W*N_OUT*N_IN  weight (i,j) = weights_OL[(i*N_IN+j)*8 +: 8]
biases_OL  in  DATA_W*N_OUT  bias i = biases_OL[i*8 +: 8]
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse, results valid
scores  out  DATA_W*N_OUT  score i = scores[i*8 +: 8], signed
digit  out  4  index of maximum score

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, scores=0, digit=0; internal counters, accumulator and activation register cleared. Reset mid-inference aborts the run: no done pulse, and outputs return to reset values.
- FSM states: IDLE, MAC, STORE.
- IDLE: done=0 except in the pulse cycle. On the edge where start=1:
  - act_in is captured into an internal register;
  - i=0, j=0, acc = sign-extended bias0 << FRAC_BITS;
  - busy<=1, state->MAC.
  - The previous scores/digit hold until they are overwritten.
- MAC: each edge adds sign-extended act[j]*w[i][j] (16-bit signed product) to acc, then j++. On j=N_IN-1, state->STORE.
- weights_OL and biases_OL are read live and must be static while busy. act_in changes after acceptance have no effect.
- STORE (1 cycle):
  - r = acc >>> FRAC_BITS (arithmetic shift, floor);
  - score i <= narrowed r (see Optional Feature);
  - if i==0 or the new score is strictly greater than the running max, max<=score and digit<=i, so ties go to the lowest index;
  - if i<N_OUT-1: i++, j=0, acc = bias(i+1)<<FRAC_BITS, state->MAC;
  - else: state->IDLE, busy<=0, done<=1 for exactly one cycle.
- Latency: 31 cycles per neuron. done rises 310 cycles after the start-accept edge.
- start while busy is ignored, with no queueing.
- start high during the done cycle is accepted, because the FSM is already in IDLE. This gives back-to-back runs.
- Accumulator cannot overflow: |acc| ≤ 30*16384 + 128*64 < 2^19.

Optional Feature:
Macro OL_SAT_EN.
- Defined: r is clamped to [-128, 127] before it is stored.
- Undefined: score = r[7:0], which wraps.
- Argmax always compares the stored 8-bit scores, so the macro affects digit.

Test Plan:
- All act=0, all weights=0, bias3=16, other biases 0 -> start; done exactly 310 cycles later; score3=16, others 0, digit=3, busy low with done.
- act0=64, other acts 0, w[i][0]=10*i, other weights 0, biases 0 -> scores=0,10,...,90; digit=9.
- All act=127, all w=127, all bias=127 -> r=7687 for every neuron. With OL_SAT_EN: all scores 127. Without: all scores 7. digit=0 in both cases (tie rule).
- All act=-128, all w=127, all bias=-128 -> r=-7748. With OL_SAT_EN: all scores -128, digit=0. act0=-64, w[i][0]=1, others 0 -> all scores -1 (floor).
- start pulsed at cycles 50 and 200 of a run -> ignored, single done at 310. rst_n low at cycle 100 -> busy=0, scores=0, digit=0, no done. A new start then completes normally.
- start held high through done -> second run accepted in the done cycle. Second done 310 cycles later, with results from act_in captured at the second accept.
